// File: rtl/router_fsm_nch_pkg.sv
// router_fsm_nch_pkg
// Shared definitions for the 1xN router controller.
// - state_e : 4-bit controller state. Nine encodings are named; any other
//   value is treated as illegal and recovers to ST_DECODE.
// - WAIT_CNT_W : width of the WAIT_EMPTY cycle counter.
package router_fsm_nch_pkg;

    typedef enum logic [3:0] {
        ST_DECODE          = 4'd0,
        ST_LOAD_FIRST      = 4'd1,
        ST_LOAD_DATA       = 4'd2,
        ST_FIFO_FULL       = 4'd3,
        ST_LOAD_AFTER_FULL = 4'd4,
        ST_LOAD_PARITY     = 4'd5,
        ST_CHECK_PARITY    = 4'd6,
        ST_WAIT_EMPTY      = 4'd7,
        ST_DROP            = 4'd8
    } state_e;

    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/router_fsm_nch_wait_timer.sv
// router_fsm_nch_wait_timer
// Cycle counter that bounds how long the controller waits for a busy
// destination FIFO to drain.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-low reset
//   clear  in  force the count to zero (has priority over enable)
//   enable in  increment the count by one
//   expire out count has reached WAIT_MAX-1; never asserts when WAIT_MAX==0
module router_fsm_nch_wait_timer
    import router_fsm_nch_pkg::*;
#(
    parameter int WAIT_MAX = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT =
        WAIT_CNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With WAIT_MAX==0 the counter simply wraps and is never reported.
    assign expire = (WAIT_MAX != 0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/router_fsm_nch.sv
// router_fsm_nch
// Control FSM for a parametrised 1xN packet router, sitting between the input
// register block and N_CH output FIFOs. Decodes the header address, sequences
// header/payload/parity loads, handles FIFO-full stalls, per-channel soft
// reset, a drop path for out-of-range addresses and an optional bounded wait
// for a busy destination FIFO.
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   pkt_valid, din    packet byte strobe and byte (header address in LSBs)
//   parity_done       parity byte has been written by the register block
//   low_pkt_valid     pkt_valid fell while the path was stalled
//   fifo_full         full flag of the selected FIFO
//   fifo_empty        per-channel empty flags
//   soft_rst          per-channel soft reset (FIFO read timeout)
//   sel_ch            latched destination channel
//   addr_valid        sel_ch holds a live, in-range channel
//   detect_add .. laf_state, rst_int_reg, write_enb_reg, busy, drop_pkt
//                     state decodes
//   wait_timeout      one-cycle pulse on the WAIT_EMPTY cycle that times out
module router_fsm_nch
    import router_fsm_nch_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic [N_CH-1:0]   fifo_empty,
    input  logic [N_CH-1:0]   soft_rst,
    output logic [ADDR_W-1:0] sel_ch,
    output logic              addr_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              drop_pkt,
    output logic              wait_timeout
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] sel_ch_q;
    logic [ADDR_W-1:0] sel_ch_d;
    logic              addr_valid_q;
    logic              addr_valid_d;

    logic [ADDR_W-1:0] hdr_addr;
    logic              hdr_in_range;
    logic              hdr_empty;
    logic              sel_empty;
    logic              sel_soft_rst;
    logic              wait_expire;
    logic              din_unused;

    assign hdr_addr     = din[ADDR_W-1:0];
    assign hdr_in_range = (32'(hdr_addr) < 32'(N_CH));
    // Only the address field of din steers the controller.
    assign din_unused   = ^din;

    // Per-channel flag muxes. Indices at or above N_CH select nothing, so an
    // out-of-range header never reads a nonexistent flag.
    always_comb begin
        hdr_empty    = 1'b0;
        sel_empty    = 1'b0;
        sel_soft_rst = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (hdr_addr == ADDR_W'(i)) begin
                hdr_empty = fifo_empty[i];
            end
            if (sel_ch_q == ADDR_W'(i)) begin
                sel_empty    = fifo_empty[i];
                sel_soft_rst = soft_rst[i];
            end
        end
    end

    // The counter is held at zero outside WAIT_EMPTY, so it reads 0 on the
    // first waiting cycle and counts up while the state is held.
    router_fsm_nch_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_WAIT_EMPTY),
        .enable (state_q == ST_WAIT_EMPTY),
        .expire (wait_expire)
    );

    always_comb begin
        state_d      = state_q;
        sel_ch_d     = sel_ch_q;
        addr_valid_d = addr_valid_q;

        case (state_q)
            ST_DECODE: begin
                if (pkt_valid) begin
                    sel_ch_d = hdr_addr;
                    if (!hdr_in_range) begin
                        state_d = ST_DROP;
                    end else if (hdr_empty) begin
                        state_d      = ST_LOAD_FIRST;
                        addr_valid_d = 1'b1;
                    end else begin
                        state_d      = ST_WAIT_EMPTY;
                        addr_valid_d = 1'b1;
                    end
                end
            end
            ST_LOAD_FIRST: begin
                state_d = ST_LOAD_DATA;
            end
            ST_LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = ST_FIFO_FULL;
                end else if (!pkt_valid) begin
                    state_d = ST_LOAD_PARITY;
                end
            end
            ST_FIFO_FULL: begin
                if (!fifo_full) begin
                    state_d = ST_LOAD_AFTER_FULL;
                end
            end
            ST_LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = ST_DECODE;
                end else if (low_pkt_valid) begin
                    state_d = ST_LOAD_PARITY;
                end else begin
                    state_d = ST_LOAD_DATA;
                end
            end
            ST_LOAD_PARITY: begin
                state_d = ST_CHECK_PARITY;
            end
            ST_CHECK_PARITY: begin
                if (fifo_full) begin
                    state_d = ST_FIFO_FULL;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_WAIT_EMPTY: begin
                // A FIFO that drains on the expiry cycle still gets the packet.
                if (sel_empty) begin
                    state_d = ST_LOAD_FIRST;
                end else if (wait_expire) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!pkt_valid) begin
                    state_d = ST_DECODE;
                end
            end
            default: begin
                state_d = ST_DECODE;
            end
        endcase

        // Soft reset of the live channel overrides whatever was decided above.
        if (addr_valid_q && sel_soft_rst) begin
            state_d = ST_DECODE;
        end

        if (state_d == ST_DECODE || state_d == ST_DROP) begin
            addr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_DECODE;
            sel_ch_q     <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_ch_q     <= sel_ch_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign sel_ch        = sel_ch_q;
    assign addr_valid    = addr_valid_q;
    assign detect_add    = (state_q == ST_DECODE);
    assign lfd_state     = (state_q == ST_LOAD_FIRST);
    assign ld_state      = (state_q == ST_LOAD_DATA);
    assign full_state    = (state_q == ST_FIFO_FULL);
    assign laf_state     = (state_q == ST_LOAD_AFTER_FULL);
    assign rst_int_reg   = (state_q == ST_CHECK_PARITY);
    assign write_enb_reg = (state_q == ST_LOAD_DATA) ||
                           (state_q == ST_LOAD_AFTER_FULL) ||
                           (state_q == ST_LOAD_PARITY);
    assign busy          = !((state_q == ST_DECODE) || (state_q == ST_LOAD_DATA));
    assign drop_pkt      = (state_q == ST_DROP);
    // Decoded from registered state and count only, so the pulse marks the
    // final permitted waiting cycle.
    assign wait_timeout  = (state_q == ST_WAIT_EMPTY) && wait_expire;

endmodule
